// File: rtl/ad7864_seq_ctrl.sv
// AD7864 sample scheduler and readout sequencer: periodic conversion start, CS/RD
// word readout of all channels, and frame hand-off to the DSP over valid/ack.
module ad7864_seq_ctrl #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned CONV_LOW = 2,
    parameter int unsigned RD_LOW   = 2,
    parameter int unsigned RD_HIGH  = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                   clkin,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       sample_div,
    output logic                   conv_bar,
    input  logic                   drv_db_rdy,
    input  logic [DATA_W-1:0]      ad_db,
    output logic                   ad_cs_bar,
    output logic                   ad_rd_bar,
    output logic [N_CH*DATA_W-1:0] frm_data,
    output logic                   frm_valid,
    input  logic                   frm_ack,
    output logic                   busy,
    output logic                   overrun,
    output logic                   missed_tick,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int unsigned CycW = 16;
    localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitRdy,
        StRdL,
        StRdH,
        StDone
    } state_e;

    state_e                         state_q, state_d;
    logic [CycW-1:0]                cyc_q, cyc_d;
    logic [ChW-1:0]                 ch_q, ch_d;
    logic [DIV_W-1:0]               cnt_q, cnt_d;
    logic [N_CH-1:0][DATA_W-1:0]    cap_q;
    logic [N_CH*DATA_W-1:0]         frm_data_q, frm_data_d;
    logic                           frm_valid_q, frm_valid_d;
    logic                           conv_bar_q, conv_bar_d;
    logic                           cs_bar_q, cs_bar_d;
    logic                           rd_bar_q, rd_bar_d;
    logic                           overrun_q, overrun_d;
    logic                           missed_q, missed_d;
    logic                           timeout_q, timeout_d;
    logic                           tick;
    logic                           to_evt;
    logic                           cap_en;
    logic                           publish;

    // Divider idles at zero so the first tick follows enable immediately.
    assign tick = enable && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = sample_div;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // State register
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ch_d    = ch_q;
        to_evt  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StConv;
                    cyc_d   = '0;
                end
            end
            StConv: begin
                if (cyc_q == CycW'(CONV_LOW - 1)) begin
                    state_d = StWaitRdy;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StWaitRdy: begin
                if (drv_db_rdy) begin
                    state_d = StRdL;
                    cyc_d   = '0;
                    ch_d    = '0;
                end else if (cyc_q == CycW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    cyc_d   = '0;
                    to_evt  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StRdL: begin
                if (cyc_q == CycW'(RD_LOW - 1)) begin
                    state_d = StRdH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StRdH: begin
                if (cyc_q == CycW'(RD_HIGH - 1)) begin
                    cyc_d = '0;
                    if (ch_q == ChW'(N_CH - 1)) begin
                        state_d = StDone;
                    end else begin
                        ch_d    = ch_q + ChW'(1);
                        state_d = StRdL;
                    end
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes decode from the next state so the registered pins change with the state.
    always_comb begin
        conv_bar_d = (state_d != StConv);
        cs_bar_d   = !((state_d == StRdL) || (state_d == StRdH));
        rd_bar_d   = (state_d != StRdL);
        busy       = (state_q != StIdle);
    end

    assign cap_en  = (state_q == StRdL) && (cyc_q == CycW'(RD_LOW - 1));
    assign publish = (state_q == StDone);

    always_comb begin
        frm_data_d  = frm_data_q;
        frm_valid_d = frm_valid_q;
        if (publish) begin
            frm_data_d  = cap_q;
            frm_valid_d = 1'b1;
        end else if (frm_ack && frm_valid_q) begin
            frm_valid_d = 1'b0;
        end

        // Set beats clear when both land in the same cycle.
        overrun_d = err_clr ? 1'b0 : overrun_q;
        missed_d  = err_clr ? 1'b0 : missed_q;
        timeout_d = err_clr ? 1'b0 : timeout_q;
        if (publish && frm_valid_q && !frm_ack) begin
            overrun_d = 1'b1;
        end
        if (tick && (state_q != StIdle)) begin
            missed_d = 1'b1;
        end
        if (to_evt) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cap_q       <= '0;
            frm_data_q  <= '0;
            frm_valid_q <= 1'b0;
            conv_bar_q  <= 1'b1;
            cs_bar_q    <= 1'b1;
            rd_bar_q    <= 1'b1;
            overrun_q   <= 1'b0;
            missed_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            if (cap_en) begin
                cap_q[ch_q] <= ad_db;
            end
            frm_data_q  <= frm_data_d;
            frm_valid_q <= frm_valid_d;
            conv_bar_q  <= conv_bar_d;
            cs_bar_q    <= cs_bar_d;
            rd_bar_q    <= rd_bar_d;
            overrun_q   <= overrun_d;
            missed_q    <= missed_d;
            timeout_q   <= timeout_d;
        end
    end

    assign conv_bar    = conv_bar_q;
    assign ad_cs_bar   = cs_bar_q;
    assign ad_rd_bar   = rd_bar_q;
    assign frm_data    = frm_data_q;
    assign frm_valid   = frm_valid_q;
    assign overrun     = overrun_q;
    assign missed_tick = missed_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ad7864_seq_ctrl.sv
// Directed bench for ad7864_seq_ctrl with a small ad7864Drv / ADC bus model.
module tb_ad7864_seq_ctrl;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned DIV_W  = 16;

    logic                   clkin = 1'b0;
    logic                   rst_n;
    logic                   enable;
    logic [DIV_W-1:0]       sample_div;
    logic                   conv_bar;
    logic                   drv_db_rdy = 1'b0;
    logic [DATA_W-1:0]      ad_db = '0;
    logic                   ad_cs_bar;
    logic                   ad_rd_bar;
    logic [N_CH*DATA_W-1:0] frm_data;
    logic                   frm_valid;
    logic                   frm_ack;
    logic                   busy;
    logic                   overrun;
    logic                   missed_tick;
    logic                   timeout_err;
    logic                   err_clr;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] words [4];
    int        rdy_delay  = 20;
    bit        rdy_en     = 1'b1;
    int        rdy_cnt    = 0;
    logic      conv_prev  = 1'b1;
    logic      rd_prev    = 1'b1;
    logic [1:0] idx       = 2'd0;
    bit        mon_on     = 1'b0;
    bit        strobe_low = 1'b0;
    int        cyc_cnt    = 0;

    ad7864_seq_ctrl #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .DIV_W   (DIV_W),
        .CONV_LOW(2),
        .RD_LOW  (2),
        .RD_HIGH (1),
        .TIMEOUT (255)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .enable     (enable),
        .sample_div (sample_div),
        .conv_bar   (conv_bar),
        .drv_db_rdy (drv_db_rdy),
        .ad_db      (ad_db),
        .ad_cs_bar  (ad_cs_bar),
        .ad_rd_bar  (ad_rd_bar),
        .frm_data   (frm_data),
        .frm_valid  (frm_valid),
        .frm_ack    (frm_ack),
        .busy       (busy),
        .overrun    (overrun),
        .missed_tick(missed_tick),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc_cnt <= cyc_cnt + 1;

    // Driver/ADC model: db_rdy pulse rdy_delay cycles after conv_bar falls,
    // word index advances on each rd_bar rise while cs_bar is low.
    always @(negedge clkin) begin
        if (drv_db_rdy) drv_db_rdy = 1'b0;
        if (rdy_cnt > 0) begin
            rdy_cnt = rdy_cnt - 1;
            if (rdy_cnt == 0) drv_db_rdy = 1'b1;
        end
        if (conv_prev && !conv_bar && rdy_en) rdy_cnt = rdy_delay;
        conv_prev = conv_bar;
        if (ad_cs_bar) idx = 2'd0;
        else if (ad_rd_bar && !rd_prev) idx = idx + 2'd1;
        rd_prev = ad_rd_bar;
        ad_db = words[idx];
        if (!mon_on) strobe_low = 1'b0;
        else if (!ad_cs_bar || !ad_rd_bar) strobe_low = 1'b1;
    end

    task automatic wait_conv_fall(input int budget, output bit ok);
        logic p;
        int   n;
        p  = conv_bar;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clkin);
            n++;
            if (p && !conv_bar) ok = 1'b1;
            p = conv_bar;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n;
        n = 0;
        while (frm_valid !== 1'b1 && n < budget) begin
            @(negedge clkin);
            n++;
        end
        ok = (frm_valid === 1'b1);
    endtask

    task automatic do_ack();
        @(negedge clkin);
        frm_ack = 1'b1;
        @(negedge clkin);
        frm_ack = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clkin);
        err_clr = 1'b1;
        @(negedge clkin);
        err_clr = 1'b0;
    endtask

    task automatic set_words(input logic [DATA_W-1:0] base);
        for (int i = 0; i < 4; i++) words[i] = base + DATA_W'(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        sample_div = 16'd99;
        frm_ack = 1'b0;
        err_clr = 1'b0;
        set_words(12'h111);
        repeat (3) @(negedge clkin);
        checks++;
        if ({conv_bar, ad_cs_bar, ad_rd_bar, frm_valid, busy, overrun, missed_tick, timeout_err}
            !== 8'b1110_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 11100000",
                     {conv_bar, ad_cs_bar, ad_rd_bar, frm_valid, busy, overrun, missed_tick,
                      timeout_err});
        end
        checks++;
        if (frm_data !== 48'h0) begin
            errors++;
            $display("FAIL reset_frm_data: got %h want 0", frm_data);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clkin);
        checks++;
        if ({busy, conv_bar} !== 2'b01) begin
            errors++;
            $display("FAIL disabled_idle: got busy,conv_bar=%b want 01", {busy, conv_bar});
        end
    endtask

    task automatic test_normal();
        bit ok;
        int t0, w, n, c, r;
        words[0] = 12'h111; words[1] = 12'h222; words[2] = 12'h333; words[3] = 12'h444;
        rdy_delay = 20;
        enable = 1'b1;
        wait_conv_fall(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL normal_first_conv: got none want fall in 10"); end
        t0 = cyc_cnt;
        w = 0;
        while (conv_bar == 1'b0 && w < 10) begin w++; @(negedge clkin); end
        checks++;
        if (w != 2) begin errors++; $display("FAIL conv_low_width: got %0d want 2", w); end
        n = 0;
        while (ad_cs_bar && n < 40) begin @(negedge clkin); n++; end
        c = 0; r = 0;
        while (!ad_cs_bar && c < 40) begin
            c++;
            if (!ad_rd_bar) r++;
            @(negedge clkin);
        end
        checks++;
        if (c != 12) begin errors++; $display("FAIL cs_low_cycles: got %0d want 12", c); end
        checks++;
        if (r != 8) begin errors++; $display("FAIL rd_low_cycles: got %0d want 8", r); end
        wait_valid(5, ok);
        checks++;
        if (frm_data !== 48'h444333222111) begin
            errors++;
            $display("FAIL normal_frame: got %h valid %b want 444333222111 valid 1",
                     frm_data, frm_valid);
        end
        checks++;
        if ({overrun, missed_tick, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL normal_flags: got %b want 000", {overrun, missed_tick, timeout_err});
        end
        do_ack();
        checks++;
        if (frm_valid !== 1'b0) begin errors++; $display("FAIL ack_clears: got %b want 0", frm_valid); end
        wait_conv_fall(120, ok);
        checks++;
        if (!ok || (cyc_cnt - t0) != 100) begin
            errors++;
            $display("FAIL conv_period: got %0d want 100", cyc_cnt - t0);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int n;
        wait_valid(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overrun_first_valid: got 0 want 1"); end
        set_words(12'h555);
        words[1] = 12'h666; words[2] = 12'h777; words[3] = 12'h888;
        n = 0;
        while (overrun !== 1'b1 && n < 150) begin @(negedge clkin); n++; end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        checks++;
        if ({frm_valid, frm_data} !== {1'b1, 48'h888777666555}) begin
            errors++;
            $display("FAIL overrun_data: got %b %h want 1 888777666555", frm_valid, frm_data);
        end
        pulse_err_clr();
        checks++;
        if ({overrun, frm_valid} !== 2'b01 || frm_data !== 48'h888777666555) begin
            errors++;
            $display("FAIL err_clr_overrun: got ovr,valid=%b data %h want 01 888777666555",
                     {overrun, frm_valid}, frm_data);
        end
    endtask

    task automatic test_ack_with_publish();
        logic p;
        int   n;
        words[0] = 12'hA01; words[1] = 12'hA02; words[2] = 12'hA03; words[3] = 12'hA04;
        p = ad_cs_bar;
        n = 0;
        while (!(!p && ad_cs_bar) && n < 150) begin
            p = ad_cs_bar;
            @(negedge clkin);
            n++;
        end
        checks++;
        if (n >= 150) begin errors++; $display("FAIL ack_pub_done: got none want cs rise in 150"); end
        frm_ack = 1'b1;
        @(negedge clkin);
        frm_ack = 1'b0;
        checks++;
        if ({frm_valid, overrun} !== 2'b10) begin
            errors++;
            $display("FAIL ack_pub_flags: got valid,ovr=%b want 10", {frm_valid, overrun});
        end
        checks++;
        if (frm_data !== 48'hA04A03A02A01) begin
            errors++;
            $display("FAIL ack_pub_data: got %h want a04a03a02a01", frm_data);
        end
        do_ack();
        checks++;
        if (frm_valid !== 1'b0) begin errors++; $display("FAIL ack_pub_clear: got %b want 0", frm_valid); end
    endtask

    task automatic test_enable_fall();
        bit ok;
        words[0] = 12'hC01; words[1] = 12'hC02; words[2] = 12'hC03; words[3] = 12'hC04;
        wait_conv_fall(120, ok);
        enable = 1'b0;
        wait_valid(60, ok);
        checks++;
        if (!ok || frm_data !== 48'hC04C03C02C01) begin
            errors++;
            $display("FAIL enable_fall_frame: got %b %h want 1 c04c03c02c01", frm_valid, frm_data);
        end
        do_ack();
        wait_conv_fall(250, ok);
        checks++;
        if (ok) begin errors++; $display("FAIL disabled_no_conv: got conv fall want none"); end
        checks++;
        if ({busy, missed_tick, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL enable_fall_idle: got %b want 000", {busy, missed_tick, timeout_err});
        end
    endtask

    task automatic test_missed_tick();
        bit ok;
        int t0, n;
        sample_div = 16'd10;
        rdy_delay = 16;
        enable = 1'b1;
        wait_conv_fall(5, ok);
        t0 = cyc_cnt;
        wait_conv_fall(60, ok);
        checks++;
        if (!ok || (cyc_cnt - t0) != 33) begin
            errors++;
            $display("FAIL missed_period: got %0d want 33", cyc_cnt - t0);
        end
        checks++;
        if (missed_tick !== 1'b1) begin errors++; $display("FAIL missed_set: got %b want 1", missed_tick); end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin @(negedge clkin); n++; end
        do_ack();
        pulse_err_clr();
        checks++;
        if ({overrun, missed_tick, timeout_err, frm_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL missed_clear: got %b want 0000",
                     {overrun, missed_tick, timeout_err, frm_valid});
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int w, n;
        rdy_en = 1'b0;
        sample_div = 16'd999;
        mon_on = 1'b1;
        enable = 1'b1;
        wait_conv_fall(5, ok);
        w = 0;
        while (conv_bar == 1'b0 && w < 10) begin @(negedge clkin); w++; end
        n = 0;
        while (timeout_err !== 1'b1 && n < 300) begin @(negedge clkin); n++; end
        checks++;
        if (n != 255) begin errors++; $display("FAIL timeout_cycles: got %0d want 255", n); end
        checks++;
        if ({busy, frm_valid} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle: got busy,valid=%b want 00", {busy, frm_valid});
        end
        enable = 1'b0;
        @(negedge clkin);
        checks++;
        if (strobe_low !== 1'b0) begin errors++; $display("FAIL timeout_strobes: got low want high"); end
        mon_on = 1'b0;
        rdy_en = 1'b1;
        pulse_err_clr();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid_frame();
        bit   ok;
        logic p;
        int   nf, n;
        words[0] = 12'hB01; words[1] = 12'hB02; words[2] = 12'hB03; words[3] = 12'hB04;
        sample_div = 16'd99;
        rdy_delay = 20;
        enable = 1'b1;
        p = ad_rd_bar;
        nf = 0;
        n = 0;
        while (nf < 3 && n < 100) begin
            @(negedge clkin);
            n++;
            if (p && !ad_rd_bar) nf++;
            p = ad_rd_bar;
        end
        checks++;
        if (nf != 3) begin errors++; $display("FAIL rst_reach_ch2: got %0d rd falls want 3", nf); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({conv_bar, ad_cs_bar, ad_rd_bar, frm_valid, busy, overrun, missed_tick, timeout_err}
            !== 8'b1110_0000 || frm_data !== 48'h0) begin
            errors++;
            $display("FAIL rst_async: got %b %h want 11100000 0",
                     {conv_bar, ad_cs_bar, ad_rd_bar, frm_valid, busy, overrun, missed_tick,
                      timeout_err}, frm_data);
        end
        @(negedge clkin);
        @(negedge clkin);
        rst_n = 1'b1;
        wait_valid(80, ok);
        checks++;
        if (!ok || frm_data !== 48'hB04B03B02B01) begin
            errors++;
            $display("FAIL rst_next_frame: got %b %h want 1 b04b03b02b01", frm_valid, frm_data);
        end
        checks++;
        if ({overrun, missed_tick, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_next_flags: got %b want 000", {overrun, missed_tick, timeout_err});
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overrun();
        test_ack_with_publish();
        test_enable_fall();
        test_missed_tick();
        test_timeout();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
